// File: rtl/delay_ctrl_pkg.sv
// Shared types and defaults for the delay-line tap sequencer.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitQuiet,
        StApply,
        StSettle
    } state_e;

    localparam int unsigned DefN      = 8;
    localparam int unsigned DefGuard  = 4;
    localparam int unsigned DefSettle = 2;
    localparam int unsigned DefDwell  = 16;
    localparam int unsigned MaxTaps   = 32;

    // Callers truncate to their own tap count; taps beyond MaxTaps are unsupported.
    function automatic logic [MaxTaps-1:0] idx_to_onehot(input int unsigned idx);
        return MaxTaps'(1) << idx;
    endfunction

endpackage

// File: rtl/pulse_quiet_detector.sv
// Synchronizes the delayed pulse and counts consecutive quiet cycles while armed.
module pulse_quiet_detector
    import delay_ctrl_pkg::*;
#(
    parameter int unsigned GUARD = DefGuard
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    input  logic arm,
    input  logic restart,
    output logic quiet
);

    localparam int unsigned CntW = $clog2(GUARD + 1);

    logic            sync1;
    logic            sync2;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            if (!arm || sync2) begin
                cnt <= '0;
            end else if (restart) begin
                // The acceptance cycle itself already counts as one quiet sample.
                cnt <= CntW'(1);
            end else if (cnt != CntW'(GUARD)) begin
                cnt <= cnt + CntW'(1);
            end
        end
    end

    assign quiet = (cnt == CntW'(GUARD));

endmodule

// File: rtl/delay_code_sequencer.sv
// Owns the one-hot tap-select bus: accepts tap requests or auto-sweeps, and only switches
// taps once the delayed pulse has been quiet for GUARD cycles.
module delay_code_sequencer
    import delay_ctrl_pkg::*;
#(
    parameter int unsigned N      = DefN,
    parameter int unsigned IDX_W  = $clog2(N),
    parameter int unsigned GUARD  = DefGuard,
    parameter int unsigned SETTLE = DefSettle,
    parameter int unsigned DWELL  = DefDwell
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             sweep_en,
    input  logic             pulse_in,
    output logic [N-1:0]     code,
    output logic [IDX_W-1:0] cur_idx,
    output logic             busy,
    output logic             done,
    output logic             err_range
);

    localparam int unsigned DwellW  = $clog2(DWELL + 1);
    localparam int unsigned SettleW = $clog2(SETTLE + 1);

    state_e               state;
    logic [IDX_W-1:0]     target;
    logic [IDX_W-1:0]     next_idx;
    logic [DwellW-1:0]    dwell_cnt;
    logic [SettleW-1:0]   settle_cnt;
    logic                 quiet;
    logic                 req_ok;
    logic                 dwell_hit;
    logic                 start_move;
    logic                 arm;

    assign req_ok     = req_valid && (32'(req_idx) < N);
    // A host request in the same cycle suppresses the sweep step.
    assign dwell_hit  = !req_valid && sweep_en && (dwell_cnt == DwellW'(DWELL - 1));
    assign start_move = (state == StIdle) && (req_ok || dwell_hit);
    assign arm        = start_move || (state == StWaitQuiet);
    assign next_idx   = (cur_idx == IDX_W'(N - 1)) ? '0 : cur_idx + IDX_W'(1);

    pulse_quiet_detector #(
        .GUARD(GUARD)
    ) u_quiet (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .arm     (arm),
        .restart (start_move),
        .quiet   (quiet)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            target     <= '0;
            code       <= N'(1);
            cur_idx    <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_range  <= 1'b0;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            done      <= 1'b0;
            err_range <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        dwell_cnt <= '0;
                        if (req_ok) begin
                            target    <= req_idx;
                            state     <= StWaitQuiet;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            err_range <= 1'b1;
                        end
                    end else if (sweep_en) begin
                        if (dwell_hit) begin
                            dwell_cnt <= '0;
                            target    <= next_idx;
                            state     <= StWaitQuiet;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            dwell_cnt <= dwell_cnt + DwellW'(1);
                        end
                    end else begin
                        dwell_cnt <= '0;
                    end
                end
                StWaitQuiet: begin
                    if (quiet) begin
                        state <= StApply;
                    end
                end
                StApply: begin
                    code       <= N'(idx_to_onehot(32'(target)));
                    cur_idx    <= target;
                    settle_cnt <= '0;
                    state      <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt == SettleW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= StIdle;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SettleW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_code_sequencer.sv
// Randomized and directed bench for delay_code_sequencer against a transaction-level model.
module tb_delay_code_sequencer;

    localparam int unsigned N      = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned GUARD  = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned DWELL  = 16;
    localparam int          MaxSteps = 4096;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_idx;
    logic             sweep_en;
    logic             pulse_in;
    logic [N-1:0]     code;
    logic [IDX_W-1:0] cur_idx;
    logic             busy;
    logic             done;
    logic             err_range;

    always #5 clk = ~clk;

    delay_code_sequencer #(
        .N     (N),
        .IDX_W (IDX_W),
        .GUARD (GUARD),
        .SETTLE(SETTLE),
        .DWELL (DWELL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_idx  (req_idx),
        .sweep_en (sweep_en),
        .pulse_in (pulse_in),
        .code     (code),
        .cur_idx  (cur_idx),
        .busy     (busy),
        .done     (done),
        .err_range(err_range)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = ready, 1 = waiting for quiet window, 2 = switched/settling.
    int k    = 0;
    int base = 1;
    bit pin_hist [MaxSteps];
    int m_phase, m_cur, m_target, m_e, m_a, m_run;
    bit m_done, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @step %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Synchronized pulse value seen by the controller at edge j.
    function automatic bit sync_sample(input int j);
        if (j - 2 >= base) return pin_hist[j - 2];
        return 1'b0;
    endfunction

    function automatic bit quiet_window(input int kk);
        for (int j = kk - int'(GUARD); j < kk; j++) begin
            if (sync_sample(j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cur   = 0;
        m_run   = 0;
        m_done  = 0;
        m_err   = 0;
        base    = k + 1;
    endtask

    task automatic model_edge(input bit v, input int idx, input bit sw, input bit p);
        pin_hist[k] = p;
        m_done = 0;
        m_err  = 0;
        if (m_phase == 0) begin
            if (v) begin
                m_run = 0;
                if (idx < int'(N)) begin
                    m_phase = 1; m_target = idx; m_e = k;
                end else begin
                    m_err = 1;
                end
            end else if (sw) begin
                m_run++;
                if (m_run == int'(DWELL)) begin
                    m_run = 0; m_phase = 1; m_target = (m_cur + 1) % int'(N); m_e = k;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_phase == 1) begin
            if (k >= m_e + int'(GUARD) && quiet_window(k)) begin
                m_phase = 2; m_a = k;
            end
        end else begin
            if (k == m_a + 1) m_cur = m_target;
            if (k == m_a + 1 + int'(SETTLE)) begin
                m_phase = 0; m_done = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("code", 32'(code), 32'(1) << m_cur);
        check_eq("cur_idx", 32'(cur_idx), 32'(m_cur));
        check_eq("req_ready", 32'(req_ready), 32'(m_phase == 0));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("err_range", 32'(err_range), 32'(m_err));
        check_eq("onehot", 32'($onehot(code)), 32'(1));
    endtask

    task automatic step(input bit v, input int idx, input bit sw, input bit p);
        @(negedge clk);
        k++;
        req_valid = v;
        req_idx   = IDX_W'(idx);
        sweep_en  = sw;
        pulse_in  = p;
        model_edge(v, idx, sw, p);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_code"}, 32'(code), 32'h01);
        check_eq({tag, "_cur"}, 32'(cur_idx), 32'h0);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'h1);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
        check_eq({tag, "_done"}, 32'(done), 32'h0);
        check_eq({tag, "_err"}, 32'(err_range), 32'h0);
        req_valid = 1'b0;
        sweep_en  = 1'b0;
        pulse_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit v, p, sw;
        int pmode;
        rst_n = 1'b1; req_valid = 1'b0; req_idx = '0; sweep_en = 1'b0; pulse_in = 1'b0;
        do_reset("rst_init");

        // Request tap 5 with a quiet line.
        step(1, 5, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        check_eq("req5_hold", 32'(code), 32'h01);
        step(0, 0, 0, 0);
        check_eq("req5_code", 32'(code), 32'h20);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("req5_done", 32'(done), 32'h1);

        // Request tap 3 while the pulse keeps firing every 3 cycles.
        step(1, 3, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, (i % 3) == 0);
        check_eq("req3_blocked", 32'(code), 32'h20);
        repeat (12) step(0, 0, 0, 0);
        check_eq("req3_code", 32'(code), 32'h08);

        // Sweep from tap 6: 7, 0, 1 at 23-cycle spacing.
        step(1, 6, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        for (int s = 1; s <= 70; s++) begin
            step(0, 0, 1, 0);
            if (s == 20) check_eq("sweep_pre", 32'(cur_idx), 32'd6);
            if (s == 21) check_eq("sweep_7", 32'(cur_idx), 32'd7);
            if (s == 44) check_eq("sweep_0", 32'(cur_idx), 32'd0);
            if (s == 67) check_eq("sweep_1", 32'(cur_idx), 32'd1);
        end
        step(0, 0, 0, 0);

        // Out-of-range request.
        step(1, 9, 0, 0);
        check_eq("err_pulse", 32'(err_range), 32'h1);
        check_eq("err_ready", 32'(req_ready), 32'h1);
        check_eq("err_code", 32'(code), 32'h02);
        step(0, 0, 0, 0);
        check_eq("err_clear", 32'(err_range), 32'h0);

        // Request on the dwell-expiry cycle beats the sweep step (which would pick 5).
        step(1, 4, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        for (int s = 1; s <= 16; s++) step(s == 16, 2, 1, 0);
        repeat (7) step(0, 0, 0, 0);
        check_eq("collide_idx", 32'(cur_idx), 32'd2);

        // Reset while stalled in the quiet wait discards the target.
        step(1, 6, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        check_eq("stall_busy", 32'(busy), 32'h1);
        do_reset("rst_mid");
        repeat (10) step(0, 0, 0, 0);
        check_eq("rst_discard", 32'(cur_idx), 32'd0);

        // Randomized traffic.
        pmode = 0;
        sw    = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset("rst_rand");
            if ($urandom_range(0, 39) == 0) pmode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 63) == 0) sw = !sw;
            v = ($urandom_range(0, 9) == 0);
            case (pmode)
                0:       p = 1'b0;
                1:       p = ($urandom_range(0, 3) == 0);
                default: p = 1'($urandom_range(0, 1));
            endcase
            step(v, int'($urandom_range(0, 11)), sw, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
